main_mem_model: RTL and testbench

Block-level main-memory responder that sits on the far end of the L2 cache's memory interface. Accepts single-block read and write requests from the L2 (`mem_read`/`mem_write` with a block address), services them from an internal block array after a fixed per-command latency, and completes each request with a one-cycle `mem_ready` pulse. An optional open-row fast path completes repeat accesses to the last-touched block early and signals `mem_hit` instead. Port names match the L2 side so the two connect by name.

---
 rtl/main_mem_pkg.sv | 28 ++
 rtl/main_mem_array.sv | 24 ++
 rtl/main_mem_model.sv | 137 +++++++++++++
 tb/tb_main_mem_model.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/main_mem_pkg.sv
// Shared types and sizing helpers for the main-memory responder model.
package main_mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic {
        CMD_RD = 1'b0,
        CMD_WR = 1'b1
    } cmd_t;

    localparam int DEF_BLOCK_SIZE = 16;
    localparam int DEF_MEM_BLOCKS = 256;
    localparam int DEF_OFF_W      = $clog2(DEF_BLOCK_SIZE);
    localparam int DEF_IDX_W      = $clog2(DEF_MEM_BLOCKS);

    // Counter only ever holds latency-1, so it needs clog2(max latency) bits.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/main_mem_array.sv
// Block storage: synchronous write port, combinational read port, no reset.
module main_mem_array #(
    parameter int BLK_W = 512,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic [BLK_W-1:0] i_wdata,
    input  logic [IDX_W-1:0] i_raddr,
    output logic [BLK_W-1:0] o_rdata
);

    logic [BLK_W-1:0] r_mem [2**IDX_W];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/main_mem_model.sv
// Main-memory responder for the L2 memory port: fixed-latency block reads/writes.
// Optional open-row fast path enabled by defining MAIN_MEM_ROW_HIT_EN.
module main_mem_model
    import main_mem_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int BLOCK_SIZE    = 16,
    parameter int MEM_BLOCKS    = 256,
    parameter int READ_LATENCY  = 8,
    parameter int WRITE_LATENCY = 8,
    parameter int HIT_LATENCY   = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [ADDR_WIDTH-1:0]            mem_addr,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_data_out,
    input  logic                             mem_read,
    input  logic                             mem_write,
    output logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_data_in,
    output logic                             mem_ready,
    output logic                             mem_hit,
    output logic [1:0]                       o_dbg_state
);

    localparam int OFF   = $clog2(BLOCK_SIZE);
    localparam int IDX   = $clog2(MEM_BLOCKS);
    localparam int BLK_W = BLOCK_SIZE * DATA_WIDTH;
    localparam int CNT_W = cnt_width(READ_LATENCY, WRITE_LATENCY, HIT_LATENCY);

    // Handshake: mem_read/mem_write are levels held by the L2 until it sees a
    // one-cycle mem_ready or mem_hit; a new request is taken only after both drop.
    state_t           r_state, w_next_state;
    cmd_t             r_cmd, w_req_cmd;
    logic [IDX-1:0]   r_idx, w_req_idx;
    logic [BLK_W-1:0] r_wdata, r_data_in, w_rdata;
    logic [CNT_W-1:0] r_cnt, w_load_val;
    logic             r_is_hit, r_ready, w_req, w_row_match;
    logic             w_accept, w_complete, w_arr_we, w_rd_load;

    wire w_unused_addr = &{1'b0, mem_addr[ADDR_WIDTH-1:OFF+IDX], mem_addr[OFF-1:0]};

    assign w_req     = mem_read | mem_write;
    assign w_req_idx = mem_addr[OFF+IDX-1:OFF];
    assign w_req_cmd = mem_write ? CMD_WR : CMD_RD;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_req)          w_next_state = S_BUSY;
            S_BUSY:  if (r_cnt == '0)    w_next_state = S_DONE;
            S_DONE:  if (!w_req)         w_next_state = S_IDLE;
            default:                     w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_accept   = (r_state == S_IDLE) && w_req;
        w_complete = (r_state == S_BUSY) && (r_cnt == '0);
        w_arr_we   = w_complete && (r_cmd == CMD_WR);
        w_rd_load  = w_complete && (r_cmd == CMD_RD);
        w_load_val = (w_req_cmd == CMD_WR) ? CNT_W'(WRITE_LATENCY - 1) : CNT_W'(READ_LATENCY - 1);
        if (w_row_match) w_load_val = CNT_W'(HIT_LATENCY - 1);
    end

`ifdef MAIN_MEM_ROW_HIT_EN
    logic [IDX-1:0] r_row_idx;
    logic           r_row_valid, r_hit;

    assign w_row_match = r_row_valid && (r_row_idx == w_req_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_idx   <= '0;
            r_row_valid <= 1'b0;
            r_hit       <= 1'b0;
        end else begin
            r_hit <= w_complete && r_is_hit;
            if (w_complete) begin
                r_row_idx   <= r_idx;
                r_row_valid <= 1'b1;
            end
        end
    end

    assign mem_hit = r_hit;
`else
    assign w_row_match = 1'b0;
    assign mem_hit     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd     <= CMD_RD;
            r_idx     <= '0;
            r_wdata   <= '0;
            r_cnt     <= '0;
            r_is_hit  <= 1'b0;
            r_data_in <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_ready <= w_complete && !r_is_hit;
            if (w_accept) begin
                r_cmd    <= w_req_cmd;
                r_idx    <= w_req_idx;
                r_wdata  <= mem_data_out;
                r_cnt    <= w_load_val;
                r_is_hit <= w_row_match;
            end else if ((r_state == S_BUSY) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_rd_load) r_data_in <= w_rdata;
        end
    end

    main_mem_array #(
        .BLK_W (BLK_W),
        .IDX_W (IDX)
    ) u_array (
        .clk     (clk),
        .i_we    (w_arr_we),
        .i_waddr (r_idx),
        .i_wdata (r_wdata),
        .i_raddr (r_idx),
        .o_rdata (w_rdata)
    );

    assign mem_data_in = r_data_in;
    assign mem_ready   = r_ready;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_main_mem_model.sv
// Self-checking bench for main_mem_model: directed plan plus random traffic
// against a block-level reference model; honours MAIN_MEM_ROW_HIT_EN.
module tb_main_mem_model;

  localparam int BLK_W = 512;
  localparam int RD_LAT = 8;
  localparam int WR_LAT = 8;
  localparam int HIT_LAT = 2;

  typedef struct {
    bit is_hit;
    int cyc;
    logic [BLK_W-1:0] din;
  } exp_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem_addr = '0;
  logic [BLK_W-1:0] mem_data_out = '0;
  logic mem_read = 1'b0;
  logic mem_write = 1'b0;
  logic [BLK_W-1:0] mem_data_in;
  logic mem_ready, mem_hit;
  logic [1:0] dbg_state;

  main_mem_model dut (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_data_out(mem_data_out),
    .mem_read(mem_read), .mem_write(mem_write), .mem_data_in(mem_data_in),
    .mem_ready(mem_ready), .mem_hit(mem_hit), .o_dbg_state(dbg_state)
  );

  // reference model state
  logic [BLK_W-1:0] m_mem [int];
  logic [BLK_W-1:0] m_din = '0;
  bit m_row_valid = 0;
  int m_row_idx = 0;
  int written_q[$];

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [BLK_W-1:0] pat(input logic [31:0] base);
    logic [BLK_W-1:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = base + i;
    return v;
  endfunction

  function automatic logic [BLK_W-1:0] rnd_blk();
    logic [BLK_W-1:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // driver: issue one request, predict its response, hold until it completes
  task automatic do_req(input bit wr, input bit both, input logic [31:0] addr,
                        input logic [BLK_W-1:0] data, input int hold_extra);
    int idx, lat, waited;
    bit hit;
    exp_t e;
    @(negedge clk);
    idx = int'((addr >> 4) & 32'hFF);
    hit = 0;
`ifdef MAIN_MEM_ROW_HIT_EN
    hit = m_row_valid && (m_row_idx == idx);
`endif
    lat = hit ? HIT_LAT : (wr ? WR_LAT : RD_LAT);
    if (wr) begin
      m_mem[idx] = data;
      written_q.push_back(idx);
    end else begin
      m_din = m_mem[idx];
    end
    m_row_valid = 1;
    m_row_idx = idx;
    e.is_hit = hit;
    e.cyc = cyc + 1 + lat;
    e.din = m_din;
    exp_q.push_back(e);
    mem_addr = addr;
    mem_data_out = data;
    mem_write = wr;
    mem_read = !wr || both;
    waited = 0;
    while (!(mem_ready || mem_hit) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk("resp_timeout", {511'd0, waited >= 200}, '0);
    repeat (hold_extra) @(negedge clk);
    mem_read = 1'b0;
    mem_write = 1'b0;
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (mem_ready && mem_hit) begin
      checks++;
      failures++;
      $display("FAIL both_pulses ready=%0b hit=%0b required one", mem_ready, mem_hit);
    end else if (mem_ready || mem_hit) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse at cycle %0d ready=%0b hit=%0b required none", cyc, mem_ready, mem_hit);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_is_hit", {511'd0, mem_hit}, {511'd0, e.is_hit});
        chk("pulse_cycle", BLK_W'(cyc), BLK_W'(e.cyc));
        chk("data_in", mem_data_in, e.din);
      end
    end
  end

  initial begin
    int idx;
    bit wr;
    logic [31:0] addr;

    // reset values
    repeat (3) @(negedge clk);
    chk("reset_ready", {511'd0, mem_ready}, '0);
    chk("reset_hit", {511'd0, mem_hit}, '0);
    chk("reset_data_in", mem_data_in, '0);
    chk("reset_state", {510'd0, dbg_state}, '0);
    rst_n = 1'b1;

    // directed plan
    do_req(1, 0, 32'h0000_0120, pat(32'hA000_0000), 0);
    do_req(1, 0, 32'h0000_0130, pat(32'hC000_0000), 0);
    do_req(0, 0, 32'h0000_012F, '0, 0);
    do_req(0, 0, 32'h0000_0120, '0, 0);
    do_req(0, 0, 32'h0000_0120, '0, 0);
    do_req(1, 0, 32'h0000_1120, pat(32'hB000_0000), 0);
    do_req(0, 0, 32'h0000_0120, '0, 0);
    do_req(0, 0, 32'h0000_0120, '0, 5);
    do_req(0, 0, 32'h0000_0120, '0, 0);
    do_req(1, 1, 32'h0000_0340, pat(32'hD000_0000), 0);

    // reset in the middle of a write
    do_req(1, 0, 32'h0000_0200, pat(32'hE000_0000), 0);
    do_req(1, 0, 32'h0000_0050, pat(32'h5000_0000), 0);
    @(negedge clk);
    mem_addr = 32'h0000_0200;
    mem_data_out = pat(32'hF000_0000);
    mem_write = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_ready", {511'd0, mem_ready}, '0);
    chk("midreset_hit", {511'd0, mem_hit}, '0);
    chk("midreset_data_in", mem_data_in, '0);
    chk("midreset_state", {510'd0, dbg_state}, '0);
    @(negedge clk);
    mem_write = 1'b0;
    rst_n = 1'b1;
    m_din = '0;
    m_row_valid = 0;
    repeat (12) @(negedge clk);
    do_req(0, 0, 32'h0000_0200, '0, 0);

    // random traffic over a few blocks so repeats and aliases are common
    for (int n = 0; n < 40; n++) begin
      wr = ($urandom_range(0, 2) == 0);
      if (wr) idx = $urandom_range(0, 7);
      else idx = written_q[$urandom_range(0, written_q.size() - 1)];
      addr = ($urandom() & 32'hFFFF_F00F) | (32'(idx) << 4);
      do_req(wr, wr && ($urandom_range(0, 7) == 0), addr, rnd_blk(), $urandom_range(0, 3));
    end

    repeat (20) @(negedge clk);
    chk("exp_q_empty", BLK_W'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
